// File: rtl/box_sched_pkg.sv
// Shared constants for the box draw scheduler: default coordinate widths,
// packed box layout and FSM state encoding.
package box_sched_pkg;

  localparam int unsigned XSZ   = 3;
  localparam int unsigned YSZ   = 3;
  localparam int unsigned BOX_W = 2 * XSZ + 2 * YSZ;

  // Packed box is {xLeft, xRight, yTop, yBottom}, MSB first
  localparam int unsigned YB_LSB = 0;
  localparam int unsigned YT_LSB = YSZ;
  localparam int unsigned XR_LSB = 2 * YSZ;
  localparam int unsigned XL_LSB = 2 * YSZ + XSZ;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GO   = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/box_fifo.sv
// Parameterised synchronous FIFO with occupancy count; full/empty gate push/pop.
module box_fifo #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage needs no reset; occupancy tracks validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/box_draw_scheduler.sv
// Arbitrates two box requesters into a FIFO, drops malformed boxes, and
// issues queued boxes one at a time to a drawer with a completion timeout.
module box_draw_scheduler #(
  parameter int unsigned XSZ     = box_sched_pkg::XSZ,
  parameter int unsigned YSZ     = box_sched_pkg::YSZ,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        req0_valid,
  input  logic [2*XSZ+2*YSZ-1:0]      req0_box,
  output logic                        req0_ready,
  input  logic                        req1_valid,
  input  logic [2*XSZ+2*YSZ-1:0]      req1_box,
  output logic                        req1_ready,
  output logic                        goDraw,
  output logic [XSZ-1:0]              xLeft,
  output logic [XSZ-1:0]              xRight,
  output logic [YSZ-1:0]              yTop,
  output logic [YSZ-1:0]              yBottom,
  input  logic                        doneDraw,
  output logic                        busy,
  output logic [$clog2(DEPTH):0]      count,
  output logic                        err,
  output logic                        timeout
);

  import box_sched_pkg::*;

  localparam int unsigned BW    = 2 * XSZ + 2 * YSZ;
  localparam int unsigned O_YB  = 0;
  localparam int unsigned O_YT  = YSZ;
  localparam int unsigned O_XR  = 2 * YSZ;
  localparam int unsigned O_XL  = 2 * YSZ + XSZ;
  localparam int unsigned TW    = $clog2(TIMEOUT + 1);

  logic [BW-1:0] head;
  logic [BW-1:0] sel_box;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          gnt0;
  logic          gnt1;
  logic          sel_bad;
  logic          last1;
  state_t        state;
  logic [TW-1:0] wait_cnt;

  // Round-robin grant; last1 set means req0 wins the next tie
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (resetn && !full) begin
      if (req0_valid && req1_valid) begin
        gnt0 = last1;
        gnt1 = !last1;
      end else begin
        gnt0 = req0_valid;
        gnt1 = req1_valid;
      end
    end
    sel_box = gnt1 ? req1_box : req0_box;
    sel_bad = (sel_box[O_XL +: XSZ] > sel_box[O_XR +: XSZ]) ||
              (sel_box[O_YT +: YSZ] > sel_box[O_YB +: YSZ]) ||
              (sel_box[O_YT +: YSZ] == '0);
    push    = (gnt0 || gnt1) && !sel_bad;
    pop     = (state == ST_IDLE) && !empty;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign busy       = (state != ST_IDLE) || !empty;

  box_fifo #(.W(BW), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .pop    (pop),
    .din    (sel_box),
    .dout   (head),
    .full   (full),
    .empty  (empty),
    .count  (count)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      last1    <= 1'b1;
      goDraw   <= 1'b0;
      err      <= 1'b0;
      timeout  <= 1'b0;
      xLeft    <= '0;
      xRight   <= '0;
      yTop     <= '0;
      yBottom  <= '0;
    end else begin
      goDraw  <= 1'b0;
      timeout <= 1'b0;
      err     <= (gnt0 || gnt1) && sel_bad;
      if (gnt0)      last1 <= 1'b0;
      else if (gnt1) last1 <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            xLeft   <= head[O_XL +: XSZ];
            xRight  <= head[O_XR +: XSZ];
            yTop    <= head[O_YT +: YSZ];
            yBottom <= head[O_YB +: YSZ];
            goDraw  <= 1'b1;
            state   <= ST_GO;
          end
        end
        ST_GO: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          // doneDraw takes priority over an expiring timeout
          if (doneDraw) begin
            state <= ST_IDLE;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            state   <= ST_IDLE;
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/box_draw_scheduler.md
BOX_DRAW_SCHEDULER -- requirements
Module: box_draw_scheduler

Interface
REQ-001 Parameters: XSZ default 3, x coordinate width; YSZ default 3, y coordinate width; DEPTH default 4, queue entries (power of 2, ≥2); TIMEOUT default 255, maximum WAIT cycles.
REQ-002 Clocking: one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  system clock, all state on rising edge.
REQ-004 resetn  in  1  synchronous active-low reset.
REQ-005 req0_valid, req1_valid  in  1 each  requester has a box to draw.
REQ-006 req0_box, req1_box  in  2*XSZ+2*YSZ each  packed {xLeft,xRight,yTop,yBottom}, MSB first.
REQ-007 req0_ready, req1_ready  out  1 each  box accepted at this edge when valid&ready.
REQ-008 goDraw  out  1  start pulse to box drawer.
REQ-009 xLeft, xRight  out  XSZ each; yTop, yBottom  out  YSZ each  registered box presented to drawer.
REQ-010 doneDraw  in  1  single-cycle completion pulse from drawer.
REQ-011 busy  out  1  FSM not IDLE or queue non-empty.
REQ-012 count  out  clog2(DEPTH)+1  queue occupancy.
REQ-013 err  out  1  one-cycle pulse: malformed box consumed and discarded.
REQ-014 timeout  out  1  one-cycle pulse: WAIT aborted by timeout.

Function
REQ-015 Arbitration: at most one requester granted per cycle; no grant while queue full; when both valid, round-robin, last-granted pointer toggles only on a grant; pointer resets to favour req0.
REQ-016 reqN_ready is combinational = grant to N; never depends on reqN_valid of the other requester except through arbitration.
REQ-017 Validation: box malformed if xLeft>xRight, yTop>yBottom, or yTop==0; malformed box is still accepted (ready=1), not queued, err pulses the following cycle.
REQ-018 Queue: FIFO of DEPTH well-formed boxes; push on valid grant, pop on IDLE→GO; no bypass; push and pop in the same cycle both take effect, count unchanged.
REQ-019 Full: ready low for both requesters; no overwrite. Empty: no pop. Pointers wrap modulo DEPTH.
REQ-020 States: IDLE, GO, WAIT.
REQ-021 IDLE→GO when queue non-empty; at that edge head entry is popped and latched into xLeft..yBottom.
REQ-022 GO: goDraw=1 for exactly one cycle; →WAIT unconditionally.
REQ-023 WAIT: coordinates held stable; →IDLE on doneDraw=1; else →IDLE with timeout pulse after TIMEOUT cycles in WAIT; wait counter cleared on entry to WAIT.
REQ-024 doneDraw outside WAIT ignored (drawer emits spurious pulse after power-up).
REQ-025 Latency: box accepted at edge t into empty queue, FSM IDLE → goDraw high in cycle t+2..t+3 (pop at t+2 edge... i.e. goDraw asserted the cycle after the pop edge); back-to-back boxes: next goDraw one cycle after returning to IDLE with queue non-empty.
REQ-026 doneDraw and timeout limit coinciding: doneDraw wins, no timeout pulse.
REQ-027 Coordinates outputs retain last box after completion until next pop.

Reset
REQ-028 resetn=0: state IDLE, queue empty, count=0, goDraw=0, err=0, timeout=0, coordinate outputs 0, RR pointer to req0, wait counter 0.
REQ-029 Reset mid-draw abandons the box without abort signalling; the drawer's next doneDraw is ignored per REQ-024.
REQ-030 ready outputs are 0 while resetn=0.

Structure
REQ-031 Shared package box_sched_pkg: XSZ, YSZ, BOX_W=2*XSZ+2*YSZ, field offsets within packed box, FSM state encoding.
REQ-032 One sub-module box_fifo (parameterised width/depth, push, pop, full, empty, count); arbitration, validation and FSM stay in the top.

Verification
REQ-033 Single req0 box {1,5,2,6}, queue empty → goDraw one cycle two cycles after acceptance, outputs 1,5,2,6 stable until doneDraw; busy falls the cycle after doneDraw.
REQ-034 Both valid every cycle, drawer stalled → grants alternate 0,1,0,1; ready drops when count=4; no entry lost or duplicated; draw order matches grant order.
REQ-035 req1 box {5,1,2,6} and {1,5,0,6} → ready=1, err pulse each, count unchanged, no goDraw.
REQ-036 TIMEOUT=8, doneDraw never driven → timeout pulse after 8 WAIT cycles, FSM IDLE, next queued box issued.
REQ-037 doneDraw pulsed while IDLE and in GO → ignored; resetn low during WAIT with 3 queued → count=0, goDraw=0, coordinates 0 next cycle.
